// File: rtl/bowling_roll_sequencer.sv
// Bowling roll sequencer: tracks frame/ball, forwards legal rolls, then steps the scorer.
// Optional legality checking is enabled by defining BOWLING_ROLL_CHECK_EN.
module bowling_roll_sequencer #(
  parameter int MAX_PINS   = 10,
  parameter int NUM_FRAMES = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_pins,
  output logic       in_ready,
  output logic       roll,
  output logic [3:0] pin_count,
  output logic       calculate_score,
  output logic [3:0] frame,
  output logic [1:0] ball,
  output logic [4:0] roll_count,
  output logic       game_over,
  output logic       err_illegal
);

  localparam int               CNT_W     = $clog2(NUM_FRAMES + 1);
  localparam logic [4:0]       MAX5      = 5'(MAX_PINS);
  localparam logic [4:0]       MAX_ROLLS = 5'(2 * NUM_FRAMES + 1);
  localparam logic [3:0]       PRE_LAST  = 4'(NUM_FRAMES - 2);
  localparam logic [CNT_W-1:0] SCORE_LEN = CNT_W'(NUM_FRAMES);

  typedef enum logic [2:0] {B1, B2, T1, T2, T3, SCORE, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       frame_q, frame_d;
  logic [3:0]       first_q, first_d;
  logic [4:0]       rem_q, rem_d;
  logic             roll_q, roll_d;
  logic [3:0]       pin_count_q, pin_count_d;
  logic [4:0]       roll_count_q, roll_count_d;
  logic             calc_q, calc_d;
  logic [CNT_W-1:0] score_cnt_q, score_cnt_d;

  logic       accept, take;
  logic [4:0] pins5, pins_sat, sum5, sum_sat;
  logic       is_strike, is_spare, t1_strike;

  assign in_ready  = (state_q == B1) || (state_q == B2) || (state_q == T1) ||
                     (state_q == T2) || (state_q == T3);
  assign accept    = in_valid && in_ready;
  assign pins5     = {1'b0, in_pins};
  assign pins_sat  = (pins5 > MAX5) ? MAX5 : pins5;
  assign sum5      = {1'b0, first_q} + pins5;
  assign sum_sat   = (sum5 > MAX5) ? MAX5 : sum5;
  assign is_strike = (pins5 == MAX5);
  assign is_spare  = (sum_sat == MAX5);
  assign t1_strike = ({1'b0, first_q} == MAX5);

`ifdef BOWLING_ROLL_CHECK_EN
  logic illegal;
  logic err_q, err_d;

  // Illegal rolls are consumed by the handshake but leave the game untouched.
  assign illegal = (pins5 > MAX5) ||
                   ((state_q == B2) && (sum5 > MAX5)) ||
                   (((state_q == T2) || (state_q == T3)) && (pins5 > rem_q));
  assign take    = accept && !illegal;
  assign err_d   = err_q || (accept && illegal);

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_illegal = err_q;
`else
  assign take        = accept;
  assign err_illegal = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    first_d      = first_q;
    rem_d        = rem_q;
    roll_d       = 1'b0;
    pin_count_d  = '0;
    roll_count_d = roll_count_q;
    calc_d       = 1'b0;
    score_cnt_d  = score_cnt_q;

    if (take) begin
      roll_d      = 1'b1;
      pin_count_d = in_pins;
      if (roll_count_q < MAX_ROLLS) roll_count_d = roll_count_q + 5'd1;
    end

    case (state_q)
      B1: if (take) begin
        if (is_strike) begin
          frame_d = frame_q + 4'd1;
          state_d = (frame_q == PRE_LAST) ? T1 : B1;
        end else begin
          first_d = in_pins;
          state_d = B2;
        end
      end
      B2: if (take) begin
        frame_d = frame_q + 4'd1;
        state_d = (frame_q == PRE_LAST) ? T1 : B1;
      end
      T1: if (take) begin
        first_d = in_pins;
        rem_d   = is_strike ? MAX5 : MAX5 - pins_sat;
        state_d = T2;
      end
      // A third ball is earned only by clearing the rack within the first two.
      T2: if (take) begin
        if (t1_strike || is_spare) begin
          rem_d   = (pins5 >= rem_q) ? MAX5 : rem_q - pins5;
          state_d = T3;
        end else begin
          score_cnt_d = '0;
          state_d     = SCORE;
        end
      end
      T3: if (take) begin
        score_cnt_d = '0;
        state_d     = SCORE;
      end
      // The registered enable lags by one cycle so it never overlaps the final roll pulse.
      SCORE: begin
        if (score_cnt_q == SCORE_LEN) begin
          state_d = DONE;
        end else begin
          calc_d      = 1'b1;
          score_cnt_d = score_cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = DONE;
      default: state_d = B1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= B1;
      frame_q      <= '0;
      first_q      <= '0;
      rem_q        <= '0;
      roll_q       <= 1'b0;
      pin_count_q  <= '0;
      roll_count_q <= '0;
      calc_q       <= 1'b0;
      score_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      first_q      <= first_d;
      rem_q        <= rem_d;
      roll_q       <= roll_d;
      pin_count_q  <= pin_count_d;
      roll_count_q <= roll_count_d;
      calc_q       <= calc_d;
      score_cnt_q  <= score_cnt_d;
    end
  end

  always_comb begin
    ball = 2'd0;
    case (state_q)
      B2, T2:  ball = 2'd1;
      T3:      ball = 2'd2;
      default: ball = 2'd0;
    endcase
  end

  assign roll            = roll_q;
  assign pin_count       = pin_count_q;
  assign calculate_score = calc_q;
  assign frame           = frame_q;
  assign roll_count      = roll_count_q;
  assign game_over       = (state_q == DONE);

endmodule

// File: tb/tb_bowling_roll_sequencer.sv
// Scoreboard bench for bowling_roll_sequencer: a frame/ball game model predicts forwarded rolls.
// Illegal-roll scenarios are exercised only when BOWLING_ROLL_CHECK_EN is defined.
module tb_bowling_roll_sequencer;

  localparam int PINS   = 10;
  localparam int FRAMES = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_pins = 4'd0;
  logic       in_ready, roll, calculate_score, game_over, err_illegal;
  logic [3:0] pin_count, frame;
  logic [1:0] ball;
  logic [4:0] roll_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cyc = 0;
  int calc_cycles = 0;
  int last_roll_cyc = 0;
  int first_calc_cyc = 0;

  // Game model: frame index, rolls taken in the current frame, and their pin counts.
  int m_frame, m_ball, m_count;
  int m_r[3];
  bit m_over, m_err;

  bowling_roll_sequencer #(.MAX_PINS(PINS), .NUM_FRAMES(FRAMES)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pins(in_pins),
    .in_ready(in_ready), .roll(roll), .pin_count(pin_count),
    .calculate_score(calculate_score), .frame(frame), .ball(ball),
    .roll_count(roll_count), .game_over(game_over), .err_illegal(err_illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Most pins the next roll may knock down, from the rules of bowling.
  function automatic int avail();
    if (m_frame < FRAMES - 1) return (m_ball == 0) ? PINS : PINS - m_r[0];
    case (m_ball)
      0:       return PINS;
      1:       return (m_r[0] == PINS) ? PINS : PINS - m_r[0];
      default: begin
        if (m_r[0] == PINS) return (m_r[1] == PINS) ? PINS : PINS - m_r[1];
        return PINS;
      end
    endcase
  endfunction

  task automatic modelRoll(input int p);
    m_r[m_ball] = p;
    m_ball++;
    m_count++;
    if (m_frame < FRAMES - 1) begin
      if (m_ball == 2 || (m_ball == 1 && p == PINS)) begin
        m_frame++;
        m_ball = 0;
      end
    end else if (m_ball == 3 ||
                 (m_ball == 2 && m_r[0] != PINS && m_r[0] + m_r[1] != PINS)) begin
      m_over = 1'b1;
    end
  endtask

  task automatic modelReset();
    m_frame = 0; m_ball = 0; m_count = 0;
    m_r[0] = 0; m_r[1] = 0; m_r[2] = 0;
    m_over = 1'b0; m_err = 1'b0;
  endtask

  task automatic runMonitor();
    int e;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        calc_cycles    = 0;
        first_calc_cyc = 0;
        exp_q.delete();
      end else begin
        if (roll) begin
          last_roll_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_roll", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pin_count", int'(pin_count), e);
          end
        end
        if (calculate_score) begin
          calc_cycles++;
          if (calc_cycles == 1) first_calc_cyc = cyc;
        end
        check("roll_calc_exclusive", int'(roll & calculate_score), 0);
      end
    end
  endtask

  task automatic checkReset();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_roll", int'(roll), 0);
    check("rst_pin_count", int'(pin_count), 0);
    check("rst_calc", int'(calculate_score), 0);
    check("rst_frame", int'(frame), 0);
    check("rst_ball", int'(ball), 0);
    check("rst_roll_count", int'(roll_count), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_err", int'(err_illegal), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkReset();
    reset = 1'b0;
    modelReset();
  endtask

  task automatic checkOutput();
    @(negedge clock);
    if (!m_over) begin
      check("frame", int'(frame), m_frame);
      check("ball", int'(ball), m_ball);
    end
    check("roll_count", int'(roll_count), m_count);
    check("in_ready", int'(in_ready), m_over ? 0 : 1);
`ifdef BOWLING_ROLL_CHECK_EN
    check("err_illegal", int'(err_illegal), int'(m_err));
`else
    check("err_illegal", int'(err_illegal), 0);
`endif
  endtask

  task automatic applyStimulus(input int p);
    bit legal;
    @(negedge clock);
    check("ready_before_roll", int'(in_ready), 1);
    legal = (p <= avail());
    if (legal) exp_q.push_back(p);
    in_valid = 1'b1;
    in_pins  = 4'(p);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_pins  = 4'd0;
    if (legal) modelRoll(p);
    else       m_err = 1'b1;
    checkOutput();
  endtask

  task automatic randomFinish();
    int a;
    int p;
    while (!m_over) begin
      a = avail();
`ifdef BOWLING_ROLL_CHECK_EN
      if ($urandom_range(0, 9) == 0) applyStimulus(int'($urandom_range(a + 1, 15)));
`endif
      p = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, a));
      applyStimulus(p);
    end
  endtask

  task automatic finishGame();
    int guard = 0;
    while (!game_over && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    check("game_over", int'(game_over), 1);
    check("calc_cycles", calc_cycles, FRAMES);
    check("calc_after_last_roll", first_calc_cyc - last_roll_cyc, 1);
    check("final_roll_count", int'(roll_count), m_count);
    check("calc_off_in_done", int'(calculate_score), 0);
    in_valid = 1'b1;
    in_pins  = 4'd3;
    repeat (3) begin
      @(negedge clock);
      check("in_ready_done", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    in_pins  = 4'd0;
    check("game_over_held", int'(game_over), 1);
  endtask

  task automatic resetDuringScore();
    int n = 0;
    int g = 0;
    while (n < 5 && g < 40) begin
      @(negedge clock);
      g++;
      if (calculate_score) n++;
    end
    check("calc_before_reset", n, 5);
    reset = 1'b1;
    @(negedge clock);
    checkReset();
    @(negedge clock);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    modelReset();
    fork
      runMonitor();
    join_none

    doReset();
    repeat (12) applyStimulus(PINS);
    finishGame();

    doReset();
    for (int i = 0; i < 20; i++) applyStimulus((i % 2 == 0) ? 4 : 5);
    finishGame();

    doReset();
    repeat (18) applyStimulus(0);
    applyStimulus(5);
    applyStimulus(5);
    applyStimulus(7);
    finishGame();

    doReset();
    repeat (18) applyStimulus(0);
    applyStimulus(10);
    applyStimulus(4);
`ifdef BOWLING_ROLL_CHECK_EN
    applyStimulus(7);
`endif
    applyStimulus(6);
    finishGame();

`ifdef BOWLING_ROLL_CHECK_EN
    doReset();
    applyStimulus(7);
    applyStimulus(5);
    applyStimulus(3);
    randomFinish();
    finishGame();

    doReset();
    repeat (18) applyStimulus(0);
    applyStimulus(11);
    randomFinish();
    finishGame();
`endif

    repeat (15) begin
      doReset();
      randomFinish();
      finishGame();
    end

    doReset();
    randomFinish();
    resetDuringScore();
    repeat (20) applyStimulus(0);
    finishGame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
